// File: rtl/otp_macro_arbiter.sv
// OTP macro command sequencer: issues Init after reset, then round-robin shares the
// single-outstanding macro command channel between NumReq requesters with a response watchdog.
package caliptra_prim_otp_pkg;
  typedef enum logic [2:0] {
    Read     = 3'b000,
    Write    = 3'b001,
    ReadRaw  = 3'b010,
    WriteRaw = 3'b011,
    Init     = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    NoError              = 3'h0,
    MacroError           = 3'h1,
    MacroEccCorrError    = 3'h2,
    MacroEccUncorrError  = 3'h3,
    MacroWriteBlankError = 3'h4
  } err_e;
endpackage

module otp_macro_arbiter
  import caliptra_prim_otp_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned Width         = 16,
  parameter int unsigned SizeWidth     = 2,
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IfWidth      = (2**SizeWidth) * Width
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumReq-1:0]                   req_valid_i,
  output logic [NumReq-1:0]                   req_ready_o,
  input  cmd_e [NumReq-1:0]                   req_cmd_i,
  input  logic [NumReq-1:0][SizeWidth-1:0]    req_size_i,
  input  logic [NumReq-1:0][AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][IfWidth-1:0]      req_wdata_i,
  output logic [NumReq-1:0]                   rsp_valid_o,
  output logic [IfWidth-1:0]                  rsp_rdata_o,
  output err_e                                rsp_err_o,
  output logic                                otp_valid_o,
  input  logic                                otp_ready_i,
  output cmd_e                                otp_cmd_o,
  output logic [SizeWidth-1:0]                otp_size_o,
  output logic [AddrWidth-1:0]                otp_addr_o,
  output logic [IfWidth-1:0]                  otp_wdata_o,
  input  logic                                otp_valid_i,
  input  logic [IfWidth-1:0]                  otp_rdata_i,
  input  err_e                                otp_err_i,
  output logic                                init_done_o,
  output logic                                fatal_err_o
);

  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  // Codewords of a shortened Hamming code: pairwise Hamming distance >= 3.
  typedef enum logic [5:0] {
    ResetSt    = 6'b100110,
    InitCmdSt  = 6'b010101,
    InitWaitSt = 6'b001011,
    IdleSt     = 6'b110011,
    CmdSt      = 6'b101101,
    WaitSt     = 6'b011110,
    ErrorSt    = 6'b111000
  } state_e;

  state_e                 state_q;
  logic [IdxW-1:0]        rr_q, owner_q;
  logic [CntW-1:0]        wdog_q;
  logic                   otp_valid_q;
  cmd_e                   cmd_q;
  logic [SizeWidth-1:0]   size_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [IfWidth-1:0]     wdata_q;
  logic [NumReq-1:0]      rsp_valid_q;
  logic [IfWidth-1:0]     rsp_rdata_q;
  err_e                   rsp_err_q;
  logic                   init_done_q, fatal_q;

  logic                   gnt_found;
  logic [IdxW-1:0]        gnt_idx, cand;
  cmd_e                   gnt_cmd;
  logic                   gnt_legal;
  logic                   wdog_hit;

  // Wrap-around search for the first valid requester at or after rr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumReq);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign gnt_cmd     = req_cmd_i[gnt_idx];
  assign gnt_legal   = gnt_cmd inside {Read, Write, ReadRaw, WriteRaw};
  assign req_ready_o = (state_q == IdleSt && gnt_found) ? (NumReq'(1) << gnt_idx) : '0;
  assign wdog_hit    = (TimeoutCycles != 0) && (32'(wdog_q) + 32'd1 >= TimeoutCycles);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ResetSt;
      rr_q        <= '0;
      owner_q     <= '0;
      wdog_q      <= '0;
      otp_valid_q <= 1'b0;
      cmd_q       <= Read;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= NoError;
      init_done_q <= 1'b0;
      fatal_q     <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ResetSt: begin
          state_q     <= InitCmdSt;
          otp_valid_q <= 1'b1;
          cmd_q       <= Init;
          size_q      <= '0;
          addr_q      <= '0;
          wdata_q     <= '0;
        end
        InitCmdSt: begin
          if (otp_ready_i) begin
            otp_valid_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= InitWaitSt;
          end
        end
        InitWaitSt: begin
          if (32'(wdog_q) < TimeoutCycles) wdog_q <= wdog_q + 1'b1;
          if (otp_valid_i) begin
            if (otp_err_i == NoError) begin
              init_done_q <= 1'b1;
              state_q     <= IdleSt;
            end else begin
              fatal_q <= 1'b1;
              state_q <= ErrorSt;
            end
          end else if (wdog_hit) begin
            fatal_q <= 1'b1;
            state_q <= ErrorSt;
          end
        end
        IdleSt: begin
          if (gnt_found) begin
            owner_q <= gnt_idx;
            rr_q    <= (32'(gnt_idx) == NumReq - 1) ? '0 : gnt_idx + 1'b1;
            if (gnt_legal) begin
              cmd_q       <= gnt_cmd;
              size_q      <= req_size_i[gnt_idx];
              addr_q      <= req_addr_i[gnt_idx];
              wdata_q     <= req_wdata_i[gnt_idx];
              otp_valid_q <= 1'b1;
              state_q     <= CmdSt;
            end else begin
              // Rejected locally; the macro never sees it and the FSM stays idle.
              rsp_valid_q[gnt_idx] <= 1'b1;
              rsp_rdata_q          <= '0;
              rsp_err_q            <= MacroError;
            end
          end
        end
        CmdSt: begin
          if (otp_ready_i) begin
            otp_valid_q <= 1'b0;
            wdog_q      <= '0;
            state_q     <= WaitSt;
          end
        end
        WaitSt: begin
          if (32'(wdog_q) < TimeoutCycles) wdog_q <= wdog_q + 1'b1;
          if (otp_valid_i) begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_rdata_q          <= otp_rdata_i;
            rsp_err_q            <= otp_err_i;
            state_q              <= IdleSt;
          end else if (wdog_hit) begin
            rsp_valid_q[owner_q] <= 1'b1;
            rsp_rdata_q          <= '0;
            rsp_err_q            <= MacroError;
            init_done_q          <= 1'b0;
            fatal_q              <= 1'b1;
            state_q              <= ErrorSt;
          end
        end
        ErrorSt: begin
          otp_valid_q <= 1'b0;
          init_done_q <= 1'b0;
          fatal_q     <= 1'b1;
        end
        default: begin
          otp_valid_q <= 1'b0;
          init_done_q <= 1'b0;
          fatal_q     <= 1'b1;
          state_q     <= ErrorSt;
        end
      endcase
    end
  end

  assign otp_valid_o = otp_valid_q;
  assign otp_cmd_o   = cmd_q;
  assign otp_size_o  = size_q;
  assign otp_addr_o  = addr_q;
  assign otp_wdata_o = wdata_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign init_done_o = init_done_q;
  assign fatal_err_o = fatal_q;

endmodule

// File: tb/tb_otp_macro_arbiter.sv
// Directed bench for otp_macro_arbiter: init, round-robin, illegal command, error passthrough,
// reset during a pending command and watchdog expiry.
module tb_otp_macro_arbiter;
  import caliptra_prim_otp_pkg::*;

  localparam int unsigned NumReq = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]        req_valid, req_ready, rsp_valid;
  cmd_e [3:0]        req_cmd;
  logic [3:0][1:0]   req_size;
  logic [3:0][9:0]   req_addr;
  logic [3:0][63:0]  req_wdata;
  logic [63:0]       rsp_rdata, otp_wdata, otp_rdata;
  err_e              rsp_err, otp_err;
  logic              otp_valid_out, otp_ready, otp_valid_in;
  cmd_e              otp_cmd;
  logic [1:0]        otp_size;
  logic [9:0]        otp_addr;
  logic              init_done, fatal_err;

  int n_tests = 0;
  int n_fail = 0;
  int init_seen = 0;
  int rsp_seen = 0;
  int wd_cycles;

  otp_macro_arbiter #(
    .NumReq(NumReq),
    .Width(16),
    .SizeWidth(2),
    .AddrWidth(10),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_cmd_i(req_cmd),
    .req_size_i(req_size),
    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .otp_valid_o(otp_valid_out),
    .otp_ready_i(otp_ready),
    .otp_cmd_o(otp_cmd),
    .otp_size_o(otp_size),
    .otp_addr_o(otp_addr),
    .otp_wdata_o(otp_wdata),
    .otp_valid_i(otp_valid_in),
    .otp_rdata_i(otp_rdata),
    .otp_err_i(otp_err),
    .init_done_o(init_done),
    .fatal_err_o(fatal_err)
  );

  always @(negedge clk) begin
    if (otp_valid_out && otp_cmd == Init) init_seen++;
    if (rsp_valid != 4'b0000) rsp_seen++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at a negedge in IdleSt with requester g's valid already set; ends at a negedge back in IdleSt.
  task automatic run_cmd(input int unsigned g, input cmd_e c, input logic [9:0] a, input logic [1:0] s,
                         input logic [63:0] wd, input logic [63:0] rd, input err_e e);
    #1;
    check_eq("grant", 64'(req_ready), 64'(1) << g);
    step();
    check_eq("otp_valid", 64'(otp_valid_out), 64'(1));
    check_eq("otp_cmd", 64'(otp_cmd), 64'(c));
    check_eq("otp_addr", 64'(otp_addr), 64'(a));
    check_eq("otp_size", 64'(otp_size), 64'(s));
    check_eq("otp_wdata", otp_wdata, wd);
    check_eq("ready_in_cmd", 64'(req_ready), 64'(0));
    step();
    check_eq("otp_valid_drop", 64'(otp_valid_out), 64'(0));
    otp_valid_in = 1'b1;
    otp_rdata    = rd;
    otp_err      = e;
    step();
    otp_valid_in = 1'b0;
    otp_rdata    = '0;
    otp_err      = NoError;
    check_eq("rsp_valid", 64'(rsp_valid), 64'(1) << g);
    check_eq("rsp_rdata", rsp_rdata, rd);
    check_eq("rsp_err", 64'(rsp_err), 64'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    req_valid    = 4'hF;
    for (int i = 0; i < 4; i++) begin
      req_cmd[i]   = Read;
      req_size[i]  = 2'(i);
      req_addr[i]  = 10'(16 * i + 1);
      req_wdata[i] = 64'h0123_4567_89AB_CD00 + 64'(i);
    end
    otp_ready    = 1'b1;
    otp_valid_in = 1'b0;
    otp_rdata    = '0;
    otp_err      = NoError;

    // Reset values
    repeat (2) step();
    check_eq("rst_otp_valid", 64'(otp_valid_out), 64'(0));
    check_eq("rst_otp_cmd", 64'(otp_cmd), 64'(Read));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check_eq("rst_rsp_err", 64'(rsp_err), 64'(NoError));
    check_eq("rst_init_done", 64'(init_done), 64'(0));
    check_eq("rst_fatal", 64'(fatal_err), 64'(0));
    check_eq("rst_ready", 64'(req_ready), 64'(0));
    req_valid = '0;

    // Init sequence
    rst_n = 1'b1;
    step();
    check_eq("init_valid", 64'(otp_valid_out), 64'(1));
    check_eq("init_cmd", 64'(otp_cmd), 64'(Init));
    check_eq("init_addr", 64'(otp_addr), 64'(0));
    step();
    check_eq("init_valid_drop", 64'(otp_valid_out), 64'(0));
    repeat (4) step();
    check_eq("init_done_early", 64'(init_done), 64'(0));
    otp_valid_in = 1'b1;
    step();
    otp_valid_in = 1'b0;
    check_eq("init_done", 64'(init_done), 64'(1));
    check_eq("init_cmd_count", 64'(init_seen), 64'(1));

    // Round-robin with all four requesters holding Read
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++)
      run_cmd(k % 4, Read, 10'(16 * (k % 4) + 1), 2'(k % 4),
              64'h0123_4567_89AB_CD00 + 64'(k % 4), 64'hA5A5_0000 + 64'(k), NoError);
    req_valid = '0;

    // Illegal command from requester 2 (pointer now at 1), requester 3 queued behind it
    req_cmd[2] = Init;
    req_valid  = 4'b1100;
    #1;
    check_eq("ill_grant", 64'(req_ready), 64'(4'b0100));
    step();
    check_eq("ill_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check_eq("ill_rsp_err", 64'(rsp_err), 64'(MacroError));
    check_eq("ill_rsp_rdata", rsp_rdata, 64'(0));
    check_eq("ill_no_otp_valid", 64'(otp_valid_out), 64'(0));
    req_valid = 4'b1000;
    run_cmd(3, Read, 10'h031, 2'd3, 64'h0123_4567_89AB_CD03, 64'h0000_1111_2222_3333, NoError);
    req_valid = '0;

    // Macro error passthrough on a write
    req_cmd[1]   = Write;
    req_addr[1]  = 10'h3F0;
    req_size[1]  = 2'd3;
    req_wdata[1] = 64'hDEAD_BEEF_CAFE_F00D;
    req_valid    = 4'b0010;
    run_cmd(1, Write, 10'h3F0, 2'd3, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, MacroWriteBlankError);
    req_valid = '0;
    check_eq("wblank_no_fatal", 64'(fatal_err), 64'(0));

    // Stray macro response while idle is ignored
    otp_valid_in = 1'b1;
    step();
    otp_valid_in = 1'b0;
    check_eq("stray_rsp", 64'(rsp_valid), 64'(0));
    check_eq("stray_fatal", 64'(fatal_err), 64'(0));

    // Reset while a read from requester 0 waits for the macro
    req_valid = 4'b0001;
    #1;
    check_eq("mid_grant", 64'(req_ready), 64'(4'b0001));
    step();
    req_valid = '0;
    check_eq("mid_otp_valid", 64'(otp_valid_out), 64'(1));
    step();
    #2;
    rst_n     = 1'b0;
    rsp_seen  = 0;
    init_seen = 0;
    #1;
    check_eq("mid_rst_otp_valid", 64'(otp_valid_out), 64'(0));
    check_eq("mid_rst_init_done", 64'(init_done), 64'(0));
    check_eq("mid_rst_cmd", 64'(otp_cmd), 64'(Read));
    repeat (2) step();
    rst_n = 1'b1;
    step();
    check_eq("reinit_valid", 64'(otp_valid_out), 64'(1));
    check_eq("reinit_cmd", 64'(otp_cmd), 64'(Init));
    step();
    otp_valid_in = 1'b1;
    step();
    otp_valid_in = 1'b0;
    check_eq("reinit_done", 64'(init_done), 64'(1));
    check_eq("reinit_no_stale_rsp", 64'(rsp_seen), 64'(0));
    check_eq("reinit_cmd_count", 64'(init_seen), 64'(1));

    // Watchdog: requester 2 reads, macro never answers
    req_cmd[2] = Read;
    req_valid  = 4'b0100;
    #1;
    check_eq("wd_grant", 64'(req_ready), 64'(4'b0100));
    step();
    req_valid = '0;
    check_eq("wd_otp_valid", 64'(otp_valid_out), 64'(1));
    wd_cycles = 0;
    do begin
      step();
      wd_cycles++;
    end while (rsp_valid === 4'b0000 && wd_cycles < 40);
    check_eq("wd_latency", 64'(wd_cycles), 64'(17));
    check_eq("wd_rsp_valid", 64'(rsp_valid), 64'(4'b0100));
    check_eq("wd_rsp_err", 64'(rsp_err), 64'(MacroError));
    check_eq("wd_fatal", 64'(fatal_err), 64'(1));
    check_eq("wd_init_done", 64'(init_done), 64'(0));

    // Error state is terminal: no grants, no macro traffic, responses ignored
    req_valid    = 4'hF;
    otp_valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("err_ready", 64'(req_ready), 64'(0));
      check_eq("err_otp_valid", 64'(otp_valid_out), 64'(0));
      check_eq("err_rsp_valid", 64'(rsp_valid), 64'(0));
      check_eq("err_fatal", 64'(fatal_err), 64'(1));
    end
    otp_valid_in = 1'b0;
    req_valid    = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
